// File: rtl/axi_cdc_chan_dst.sv
// Destination half of a gray-pointer CDC FIFO channel.
// Syncs the write pointer, pops into a registered valid/ready output.
module axi_cdc_chan_dst #(
    parameter type T          = logic,
    parameter int  LogDepth   = 1,
    parameter int  SyncStages = 2
) (
    input  logic                   dst_clk_i,
    input  logic                   dst_rst_ni,
    output T                       dst_data_o,
    output logic                   dst_valid_o,
    input  logic                   dst_ready_i,
    output logic [LogDepth:0]      dst_occupancy_o,
    input  T [2**LogDepth-1:0]     async_data_i,
    input  logic [LogDepth:0]      async_wptr_i,
    output logic [LogDepth:0]      async_rptr_o
);

    localparam int Depth = 2**LogDepth;

    typedef logic [LogDepth:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[LogDepth] = g[LogDepth];
        for (int i = LogDepth - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    ptr_t r_wsync [SyncStages];
    ptr_t r_rptr_bin;
    ptr_t r_rptr_gray;
    T     r_data;
    logic r_valid;

    ptr_t w_wptr_gray_s;
    ptr_t w_rptr_bin_nxt;
    logic w_empty;
    logic w_pop;

    assign w_wptr_gray_s  = r_wsync[SyncStages-1];
    assign w_rptr_bin_nxt = r_rptr_bin + ptr_t'(1);
    assign w_empty        = (w_wptr_gray_s == r_rptr_gray);
    assign w_pop          = !w_empty && (!r_valid || dst_ready_i);

    assign dst_data_o      = r_data;
    assign dst_valid_o     = r_valid;
    assign async_rptr_o    = r_rptr_gray;
    assign dst_occupancy_o = gray2bin(w_wptr_gray_s) - r_rptr_bin;

    // Shift the raw gray write pointer through the synchronizer chain
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            for (int i = 0; i < SyncStages; i++) begin
                r_wsync[i] <= '0;
            end
        end else begin
            r_wsync[0] <= async_wptr_i;
            for (int i = 1; i < SyncStages; i++) begin
                r_wsync[i] <= r_wsync[i-1];
            end
        end
    end

    // Pop into the output register, advance the read pointer pair
    always_ff @(posedge dst_clk_i or negedge dst_rst_ni) begin
        if (!dst_rst_ni) begin
            r_rptr_bin  <= '0;
            r_rptr_gray <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else if (w_pop) begin
            r_data      <= async_data_i[r_rptr_bin[LogDepth-1:0]];
            r_valid     <= 1'b1;
            r_rptr_bin  <= w_rptr_bin_nxt;
            r_rptr_gray <= bin2gray(w_rptr_bin_nxt);
        end else if (r_valid && dst_ready_i) begin
            r_valid     <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    a_params : assert property (@(posedge dst_clk_i)
        LogDepth >= 1 && SyncStages >= 2);

    a_occ : assert property (@(posedge dst_clk_i)
        disable iff (!dst_rst_ni)
        dst_occupancy_o <= ptr_t'(Depth));

    a_hold : assert property (@(posedge dst_clk_i)
        disable iff (!dst_rst_ni)
        dst_valid_o && !dst_ready_i
        |=> dst_valid_o && $stable(dst_data_o));

    a_gray : assert property (@(posedge dst_clk_i)
        disable iff (!dst_rst_ni)
        async_rptr_o != $past(async_rptr_o)
        |-> $onehot(async_rptr_o ^ $past(async_rptr_o)));
`endif

endmodule

// File: tb/tb_axi_cdc_chan_dst.sv
// Bench for axi_cdc_chan_dst: source-half model plus scoreboard.
// LogDepth=2, SyncStages=2, 32-bit payload.
module tb_axi_cdc_chan_dst;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ready;
    logic [3:0][31:0] mem;
    logic [2:0]       wgray;
    logic [2:0]       wbin;
    logic [31:0]      data;
    logic             valid;
    logic [2:0]       occ;
    logic [2:0]       rptr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_cdc_chan_dst #(
        .T          (logic [31:0]),
        .LogDepth   (2),
        .SyncStages (2)
    ) dut (
        .dst_clk_i       (clk),
        .dst_rst_ni      (rst_n),
        .dst_data_o      (data),
        .dst_valid_o     (valid),
        .dst_ready_i     (ready),
        .dst_occupancy_o (occ),
        .async_data_i    (mem),
        .async_wptr_i    (wgray),
        .async_rptr_o    (rptr)
    );

    function automatic logic [2:0] g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse gray by search over all pointer values
    function automatic logic [2:0] g2b(input logic [2:0] x);
        for (int i = 0; i < 8; i++) begin
            if (g(3'(i)) == x) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic src_full();
        return 3'(wbin - g2b(rptr)) == 3'd4;
    endfunction

    task automatic src_push(input logic [31:0] v);
        mem[wbin[1:0]] = v;
        wbin = wbin + 3'd1;
        wgray = g(wbin);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wbin = 3'd0;
        wgray = 3'd0;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        src_push(32'h0000_BEEF);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid got=%b exp=0", valid);
        end
        n_chk++;
        if (rptr !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_rptr got=%b exp=000", rptr);
        end
        n_chk++;
        if (occ !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_occ got=%0d exp=0", occ);
        end
        wbin = 3'd0;
        wgray = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if ({valid, rptr, occ} !== 7'd0) begin
            n_fail++;
            $display("FAIL rst_hold got v=%b r=%b o=%0d exp 0",
                     valid, rptr, occ);
        end
    endtask

    task automatic single_beat(input logic [31:0] v, input string nm);
        mem[0] = v;
        src_push(v);
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_early got valid=%b exp=0", nm, valid);
        end
        @(posedge clk);
        #1;
        n_chk++;
        if (valid !== 1'b1 || data !== v) begin
            n_fail++;
            $display("FAIL %s_beat got v=%b d=%h exp v=1 d=%h",
                     nm, valid, data, v);
        end
        n_chk++;
        if (rptr !== 3'b001 || occ !== 3'd0) begin
            n_fail++;
            $display("FAIL %s_ptr got r=%b o=%0d exp r=001 o=0",
                     nm, rptr, occ);
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain got valid=%b exp=0", nm, valid);
        end
        ready = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        single_beat(32'hA5A5_0001, "single");
    endtask

    task automatic test_full_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) src_push(32'h10 + 32'(i));
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (valid !== 1'b1 || data !== 32'h10) begin
            n_fail++;
            $display("FAIL full_head got v=%b d=%h exp v=1 d=10",
                     valid, data);
        end
        n_chk++;
        if (occ !== 3'd3 || rptr !== 3'b001) begin
            n_fail++;
            $display("FAIL full_ptr got o=%0d r=%b exp o=3 r=001",
                     occ, rptr);
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (valid !== 1'b1 || data !== 32'h10 || occ !== 3'd3) begin
            n_fail++;
            $display("FAIL full_hold got v=%b d=%h o=%0d exp 1 10 3",
                     valid, data, occ);
        end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (valid !== 1'b1 || data !== 32'h10 + 32'(i)) begin
                n_fail++;
                $display("FAIL full_drain%0d got v=%b d=%h exp v=1 d=%h",
                         i, valid, data, 32'h10 + 32'(i));
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty got valid=%b exp=0", valid);
        end
        ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [2:0]  wexp [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7,
                                   3'd5, 3'd4, 3'd0, 3'd1, 3'd3};
        logic [2:0]  rq [$];
        logic [31:0] exp [$];
        logic [31:0] v;
        int pushed = 0;
        int got = 0;
        do_reset();
        ready = 1'b1;
        rq.push_back(rptr);
        for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
            if (pushed < 10 && !src_full()) begin
                v = $urandom;
                exp.push_back(v);
                src_push(v);
                pushed++;
            end
            if (valid && ready) begin
                n_chk++;
                if (exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL wrap_dup got d=%h exp none", data);
                end else begin
                    v = exp.pop_front();
                    if (data !== v) begin
                        n_fail++;
                        $display("FAIL wrap_data got=%h exp=%h", data, v);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (rptr != rq[$]) rq.push_back(rptr);
        end
        n_chk++;
        if (got != 10) begin
            n_fail++;
            $display("FAIL wrap_count got=%0d exp=10", got);
        end
        n_chk++;
        if (rq.size() != 11) begin
            n_fail++;
            $display("FAIL wrap_rlen got=%0d exp=11", rq.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_chk++;
                if (rq[i] !== wexp[i]) begin
                    n_fail++;
                    $display("FAIL wrap_rptr%0d got=%b exp=%b",
                             i, rq[i], wexp[i]);
                end
            end
        end
        ready = 1'b0;
    endtask

    task automatic test_random_ready();
        logic [31:0] exp [$];
        logic [31:0] v;
        logic [31:0] pd;
        logic pv;
        logic pr;
        int pushed = 0;
        int got = 0;
        do_reset();
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            if (pushed < 1000 && !src_full() && $urandom_range(1) == 1) begin
                v = $urandom;
                exp.push_back(v);
                src_push(v);
                pushed++;
            end
            ready = $urandom_range(1) == 1;
            if (valid && ready) begin
                n_chk++;
                if (exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_dup got d=%h exp none", data);
                end else begin
                    v = exp.pop_front();
                    if (data !== v) begin
                        n_fail++;
                        $display("FAIL rnd_data beat=%0d got=%h exp=%h",
                                 got, data, v);
                    end
                end
                got++;
            end
            pv = valid;
            pr = ready;
            pd = data;
            @(posedge clk);
            #1;
            if (pv && !pr) begin
                n_chk++;
                if (valid !== 1'b1 || data !== pd) begin
                    n_fail++;
                    $display("FAIL rnd_hold got v=%b d=%h exp v=1 d=%h",
                             valid, data, pd);
                end
            end
            n_chk++;
            if (occ > 3'd4) begin
                n_fail++;
                $display("FAIL rnd_occ got=%0d exp<=4", occ);
            end
        end
        n_chk++;
        if (got != 1000 || exp.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_count got=%0d left=%0d exp 1000 0",
                     got, exp.size());
        end
        ready = 1'b0;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) src_push(32'h77 + 32'(i));
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (valid !== 1'b1 || data !== 32'h77) begin
            n_fail++;
            $display("FAIL mid_pre got v=%b d=%h exp v=1 d=77",
                     valid, data);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (valid !== 1'b0 || rptr !== 3'd0 || occ !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_rst got v=%b r=%b o=%0d exp 0 000 0",
                     valid, rptr, occ);
        end
        wbin = 3'd0;
        wgray = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        single_beat(32'hA5A5_0002, "mid_after");
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        mem = '0;
        wbin = 3'd0;
        wgray = 3'd0;
        test_reset();
        test_single();
        test_full_backpressure();
        test_wrap();
        test_random_ready();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
